vr_cond: RTL and testbench
==========================

VR_COND -- requirements
Module: vr_cond

Interface
REQ-001 SHALL have: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: vr_in  input  1  raw VR/crank comparator output, asynchronous to clk.
REQ-004 SHALL have: flt_len  input  8  qualification length in clk cycles; 0 treated as 1.
REQ-005 SHALL have: blank_len  input  16  lockout cycles after an accepted rising edge; 0 = no lockout.
REQ-006 SHALL have: cap  output  1  filtered tooth level, fed to the angle generator cap input.
REQ-007 SHALL have: cap_edge  output  1  one-cycle pulse on each accepted rising edge of cap.
REQ-008 SHALL have: noise_cnt  output  8  saturating count of rejected glitches.

Function
REQ-009 SHALL synchronise vr_in through two flops (vr_s = second flop) and keep vr_p = vr_s delayed one cycle.
REQ-010 SHALL implement FSM states LOW, RISE_QUAL, HIGH, FALL_QUAL; cap = 1 in HIGH and FALL_QUAL only, registered.
REQ-011 LOW: vr_s=1 and bcnt=0 -> RISE_QUAL, qcnt<=1; vr_s=1 and bcnt!=0 -> stay LOW.
REQ-012 RISE_QUAL: vr_s=0 -> LOW, noise event; else qcnt>=max(flt_len,1) -> HIGH, cap_edge<=1, bcnt<=blank_len; else qcnt<=qcnt+1.
REQ-013 HIGH: vr_s=0 -> FALL_QUAL, qcnt<=1.
REQ-014 FALL_QUAL: vr_s=1 -> HIGH, noise event; else qcnt>=max(flt_len,1) -> LOW; else qcnt<=qcnt+1.
REQ-015 Latency vr_in rising (first sampling edge) to cap high SHALL be max(flt_len,1)+3 clk cycles; same for falling.
REQ-016 bcnt (16 bit) SHALL decrement by 1 every cycle while nonzero, in every state; it SHALL be loaded, not decremented, in the cycle of an accepted rise.
REQ-017 In LOW with bcnt!=0, a rising edge of vr_s (vr_s=1, vr_p=0) SHALL count one noise event; held-high vr_s SHALL NOT count repeatedly.
REQ-018 Held-high vr_s when bcnt reaches 0 in LOW SHALL start RISE_QUAL the following cycle.
REQ-019 qcnt SHALL be 8 bit and SHALL NOT wrap; it stops incrementing once >= flt_len.
REQ-020 flt_len or blank_len changes SHALL take effect on the next comparison/load; no restart of in-progress qualification.
REQ-021 noise_cnt SHALL increment by 1 per noise event and saturate at 255; at most one event per cycle.
REQ-022 cap_edge SHALL be high for exactly one cycle per accepted rise, coincident with the cycle cap first reads 1.

Reset
REQ-023 rst high SHALL immediately clear sync flops, vr_p, qcnt, bcnt, noise_cnt to 0, FSM to LOW, cap=0, cap_edge=0.
REQ-024 Reset mid-qualification or mid-lockout SHALL abandon it; no edge or noise event generated on release.
REQ-025 After rst deasserts, first sampling of vr_in SHALL occur on the next clk rising edge.

Configuration
REQ-026 Macro VR_COND_NOISE_CNT_EN defined: noise counter per REQ-017/021 present.
REQ-027 Macro VR_COND_NOISE_CNT_EN undefined: no counter logic, noise_cnt tied to 0; filtering and lockout unchanged.

Verification
REQ-028 flt_len=4, blank_len=0, vr_in 0->1 held 20 cycles -> cap high 7 cycles after first sampling edge, one cap_edge pulse, noise_cnt=0.
REQ-029 flt_len=4, vr_in high pulse 3 cycles wide from LOW -> cap stays 0, noise_cnt=1.
REQ-030 flt_len=2, blank_len=50, accepted rise, vr_in low at +10, re-high at +20 held -> rise at +20 ignored (noise_cnt=1), cap re-rises 3 cycles after bcnt hits 0.
REQ-031 flt_len=0 -> behaves as flt_len=1: 1-cycle high pulse rejected, 2-cycle pulse accepted with latency 4.
REQ-032 300 rejected 1-cycle glitches with flt_len=8 -> noise_cnt=255 (macro defined) or 0 (undefined).
REQ-033 rst asserted during RISE_QUAL with qcnt=3 -> cap=0, noise_cnt=0, no cap_edge after release with vr_in held low.

Source files
------------

// File: rtl/vr_cond_if.sv
// Bundle of the conditioner's signal-side ports: raw comparator input, filter
// settings, and the filtered tooth outputs.
interface vr_cond_if;
    logic        vr_in;
    logic [7:0]  flt_len;
    logic [15:0] blank_len;
    logic        cap;
    logic        cap_edge;
    logic [7:0]  noise_cnt;

    modport master (
        output vr_in, flt_len, blank_len,
        input  cap, cap_edge, noise_cnt
    );

    modport slave (
        input  vr_in, flt_len, blank_len,
        output cap, cap_edge, noise_cnt
    );
endinterface

// File: rtl/vr_cond.sv
// VR/crank signal conditioner: 2-flop sync, qualification FSM, post-rise lockout.
// Define VR_COND_NOISE_CNT_EN to build the saturating rejected-glitch counter.
module vr_cond (
    input  logic     clk,
    input  logic     rst,
    vr_cond_if.slave bus
);

    typedef enum logic [1:0] {LOW, RISE_QUAL, HIGH, FALL_QUAL} state_e;

    state_e      state_q, state_d;
    logic        sync1_q, vr_s_q;
    logic [7:0]  qcnt_q, qcnt_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        cap_q, cap_d;
    logic        cap_edge_q;
    logic [7:0]  flt_eff;

    assign flt_eff = (bus.flt_len == 8'd0) ? 8'd1 : bus.flt_len;
    assign cap_d   = (state_q == HIGH) || (state_q == FALL_QUAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            vr_s_q     <= 1'b0;
            state_q    <= LOW;
            qcnt_q     <= 8'd0;
            bcnt_q     <= 16'd0;
            cap_q      <= 1'b0;
            cap_edge_q <= 1'b0;
        end else begin
            sync1_q    <= bus.vr_in;
            vr_s_q     <= sync1_q;
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            bcnt_q     <= bcnt_d;
            cap_q      <= cap_d;
            cap_edge_q <= cap_d & ~cap_q;
        end
    end

    // Lockout counts down everywhere; only an accepted rise reloads it.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        bcnt_d  = (bcnt_q != 16'd0) ? bcnt_q - 16'd1 : 16'd0;
        case (state_q)
            LOW: begin
                if (vr_s_q && (bcnt_q == 16'd0)) begin
                    state_d = RISE_QUAL;
                    qcnt_d  = 8'd1;
                end
            end
            RISE_QUAL: begin
                if (!vr_s_q) begin
                    state_d = LOW;
                end else if (qcnt_q >= flt_eff) begin
                    state_d = HIGH;
                    bcnt_d  = bus.blank_len;
                end else begin
                    qcnt_d  = qcnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (!vr_s_q) begin
                    state_d = FALL_QUAL;
                    qcnt_d  = 8'd1;
                end
            end
            FALL_QUAL: begin
                if (vr_s_q) begin
                    state_d = HIGH;
                end else if (qcnt_q >= flt_eff) begin
                    state_d = LOW;
                end else begin
                    qcnt_d  = qcnt_q + 8'd1;
                end
            end
            default: state_d = LOW;
        endcase
    end

    assign bus.cap      = cap_q;
    assign bus.cap_edge = cap_edge_q;

`ifdef VR_COND_NOISE_CNT_EN
    logic       vr_p_q;
    logic       noise_evt;
    logic [7:0] noise_cnt_q, noise_cnt_d;

    // A lockout-blocked rise counts once on the vr_s edge, not while held high.
    always_comb begin
        noise_evt = 1'b0;
        case (state_q)
            LOW:       noise_evt = vr_s_q && !vr_p_q && (bcnt_q != 16'd0);
            RISE_QUAL: noise_evt = !vr_s_q;
            FALL_QUAL: noise_evt = vr_s_q;
            default:   noise_evt = 1'b0;
        endcase
        noise_cnt_d = noise_cnt_q;
        if (noise_evt && (noise_cnt_q != 8'hFF)) begin
            noise_cnt_d = noise_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vr_p_q      <= 1'b0;
            noise_cnt_q <= 8'd0;
        end else begin
            vr_p_q      <= vr_s_q;
            noise_cnt_q <= noise_cnt_d;
        end
    end

    assign bus.noise_cnt = noise_cnt_q;
`else
    assign bus.noise_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vr_cond.sv
// Directed bench for vr_cond: an input-history reference model checked every
// cycle, plus literal latency/count expectations for the key scenarios.
module tb_vr_cond;

`ifdef VR_COND_NOISE_CNT_EN
    localparam bit NOISE_EN = 1'b1;
`else
    localparam bit NOISE_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    vr_cond_if bus ();

    vr_cond dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: filtered level flips once the synchronised input has
    // disagreed with it for max(flt_len,1)+1 consecutive cycles.
    logic [2:0] hist;
    logic       lvl, cap_m, edge_m;
    int         run, lock, noise_m;

    always @(posedge clk or posedge rst) begin
        logic vs, vp, lvl_old, ev;
        int   leff, lock_next;
        if (rst) begin
            hist = '0; lvl = 0; cap_m = 0; edge_m = 0;
            run = 0; lock = 0; noise_m = 0;
        end else begin
            vs        = hist[1];
            vp        = hist[2];
            ev        = 1'b0;
            lvl_old   = lvl;
            edge_m    = lvl_old && !cap_m;
            cap_m     = lvl_old;
            leff      = (bus.flt_len == 0) ? 1 : int'(bus.flt_len);
            lock_next = (lock > 0) ? lock - 1 : 0;
            if (vs == lvl) begin
                if (run > 0) ev = 1'b1;
                run = 0;
            end else if (!lvl && lock > 0 && run == 0) begin
                if (!vp) ev = 1'b1;
            end else begin
                run++;
                if (run > leff) begin
                    lvl = !lvl;
                    run = 0;
                    if (lvl) lock_next = int'(bus.blank_len);
                end
            end
            lock = lock_next;
            if (ev && NOISE_EN && noise_m < 255) noise_m++;
            hist = {hist[1:0], bus.vr_in};
        end
    end

    int   edge_cnt  = 0;
    int   last_rise = -1;
    logic cap_prev  = 1'b0;

    always @(negedge clk) begin
        chk("cap", int'(bus.cap), int'(cap_m));
        chk("cap_edge", int'(bus.cap_edge), int'(edge_m));
        chk("noise_cnt", int'(bus.noise_cnt), noise_m);
        if (bus.cap_edge) edge_cnt++;
        if (bus.cap && !cap_prev) last_rise = cyc;
        cap_prev = bus.cap;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int t0, e0;
        rst = 1'b1;
        bus.vr_in = 1'b0;
        bus.flt_len = 8'd4;
        bus.blank_len = 16'd0;
        step(3);
        chk("rst_cap", int'(bus.cap), 0);
        chk("rst_edge", int'(bus.cap_edge), 0);
        chk("rst_noise", int'(bus.noise_cnt), 0);
        rst = 1'b0;
        step(2);

        // Clean rise, flt_len=4: cap seven cycles after first sampling edge.
        e0 = edge_cnt;
        bus.vr_in = 1'b1; t0 = cyc + 1;
        step(20);
        chk("t1_latency", last_rise - t0, 7);
        chk("t1_edges", edge_cnt - e0, 1);
        chk("t1_noise", int'(bus.noise_cnt), 0);
        chk("t1_cap_high", int'(bus.cap), 1);
        // One-cycle low glitch while high is rejected.
        bus.vr_in = 1'b0; step(1); bus.vr_in = 1'b1; step(8);
        chk("t1_glitch_cap", int'(bus.cap), 1);
        chk("t1_glitch_noise", int'(bus.noise_cnt), NOISE_EN ? 1 : 0);
        bus.vr_in = 1'b0; step(12);
        chk("t1_fall_cap", int'(bus.cap), 0);

        // Three-cycle pulse with flt_len=4 is rejected.
        e0 = edge_cnt;
        bus.vr_in = 1'b1; step(3); bus.vr_in = 1'b0; step(10);
        chk("t2_edges", edge_cnt - e0, 0);
        chk("t2_noise", int'(bus.noise_cnt), NOISE_EN ? 2 : 0);

        // Lockout: rise inside blank window is ignored until the window expires.
        bus.flt_len = 8'd2; bus.blank_len = 16'd50;
        e0 = edge_cnt;
        t0 = cyc;
        bus.vr_in = 1'b1; step(10);
        chk("t3_first_rise", last_rise - t0, 6);
        bus.vr_in = 1'b0; step(10);
        chk("t3_low_cap", int'(bus.cap), 0);
        bus.vr_in = 1'b1; step(30);
        chk("t3_blocked_cap", int'(bus.cap), 0);
        chk("t3_noise", int'(bus.noise_cnt), NOISE_EN ? 3 : 0);
        step(30);
        chk("t3_rerise", last_rise - t0, 59);
        chk("t3_edges", edge_cnt - e0, 2);
        chk("t3_noise_held", int'(bus.noise_cnt), NOISE_EN ? 3 : 0);
        bus.vr_in = 1'b0; step(70);

        // flt_len=0 acts as 1: 1-cycle pulse rejected, 2-cycle accepted.
        bus.flt_len = 8'd0; bus.blank_len = 16'd0;
        e0 = edge_cnt;
        bus.vr_in = 1'b1; step(1); bus.vr_in = 1'b0; step(8);
        chk("t4_short_edges", edge_cnt - e0, 0);
        chk("t4_noise", int'(bus.noise_cnt), NOISE_EN ? 4 : 0);
        bus.vr_in = 1'b1; t0 = cyc + 1; step(2); bus.vr_in = 1'b0; step(10);
        chk("t4_latency", last_rise - t0, 4);
        chk("t4_edges", edge_cnt - e0, 1);
        chk("t4_fall_cap", int'(bus.cap), 0);

        // Reset in the middle of rise qualification (qcnt=3).
        bus.flt_len = 8'd8;
        bus.vr_in = 1'b1; step(5);
        rst = 1'b1; bus.vr_in = 1'b0;
        #1;
        chk("t5_rst_noise", int'(bus.noise_cnt), 0);
        step(2);
        rst = 1'b0;
        e0 = edge_cnt;
        step(15);
        chk("t5_cap", int'(bus.cap), 0);
        chk("t5_noise", int'(bus.noise_cnt), 0);
        chk("t5_edges", edge_cnt - e0, 0);

        // 300 one-cycle glitches saturate the counter.
        for (int i = 0; i < 300; i++) begin
            bus.vr_in = 1'b1; step(1);
            bus.vr_in = 1'b0; step(2);
        end
        step(4);
        chk("t6_noise_sat", int'(bus.noise_cnt), NOISE_EN ? 255 : 0);
        chk("t6_cap", int'(bus.cap), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d done", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
